error_response_decoder: RTL and testbench
=========================================

Name: error_response_decoder

Overview:
- Initiator-side parser for incoming authentication responses. Accepts the response byte-serially from the receive path, captures the 4-byte header (ProtocolVersion, MessageType, Param1, Param2) and classifies ERROR responses into error flags.
- Tracks consecutive Busy errors to drive retry or give-up decisions for the authentication driver FSM.
- Non-ERROR messages are consumed and flagged as non-error, so the driver can route them to the response handlers.

Parameters:
- PROTOCOL_VERSION, 8'h01, expected header byte 0.
- ERROR_RESP_CMD, 8'h7F, MessageType value identifying an ERROR response.
- MAX_BUSY_RETRIES, 3, number of consecutive Busy errors at which the block gives up (range 1..15).
- RX_TIMEOUT, 1023, maximum idle cycles between accepted bytes of one message (10-bit counter).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- Enable, in, 1: block enable.
- rx_byte, in, 8: received byte.
- rx_valid, in, 1: rx_byte is valid.
- rx_last, in, 1: current byte is the final byte of the message.
- rx_ready, out, 1: block can accept a byte; a byte is accepted when rx_valid & rx_ready.
- err_valid, out, 1: one-cycle pulse; all result outputs are updated this cycle.
- is_error_resp, out, 1: the last message was a well-formed ERROR response.
- Error_Invalid_Request, out, 1: held flag.
- Error_Unsupported_Protocol, out, 1: held flag.
- Error_Busy, out, 1: held flag.
- Error_Unspecified, out, 1: held flag.
- Error_Unknown_Code, out, 1: held flag; Param1 not in 0x01..0x04.
- param1, out, 8: captured Param1.
- param2, out, 8: captured Param2.
- malformed, out, 1: held flag; last message violated framing.
- busy_retry, out, 1: one-cycle pulse; coincides with err_valid.
- busy_give_up, out, 1: held flag.
- clear, in, 1: clears all held flags and busy_give_up.

Behaviour:
- Reset: all outputs are 0, FSM in IDLE, byte index 0, busy counter 0, timeout counter 0.
- FSM states: IDLE, HDR, DRAIN, REPORT.
  - IDLE: rx_ready=1 when Enable. First accepted byte → HDR, captured as byte 0.
  - HDR: accepts bytes 1..3.
    - rx_last on byte index <3 → REPORT with malformed (short message).
    - Byte 3 with rx_last → REPORT.
    - Byte 3 without rx_last → DRAIN.
  - DRAIN: accepts and discards bytes until rx_last, then → REPORT. An ERROR response carrying payload is malformed. A non-ERROR message is not.
  - REPORT: rx_ready=0 for one cycle. err_valid=1 and all held outputs update; then → IDLE. Latency: final byte accepted in cycle N → err_valid in cycle N+1. Earliest next byte acceptance is N+2.
- Classification, in priority order:
  1. Framing error (short, timeout, or payload on ERROR) → malformed=1; all error flags 0.
  2. Byte 0 ≠ PROTOCOL_VERSION → malformed=1.
  3. Byte 1 ≠ ERROR_RESP_CMD → is_error_resp=0, flags 0.
  4. Otherwise is_error_resp=1, and exactly one flag is set from Param1: 0x01 Invalid_Request, 0x02 Unsupported_Protocol, 0x03 Busy, 0x04 Unspecified, else Unknown_Code.
- param1 and param2 are loaded whenever byte 3 was captured; otherwise they are 0.
- Timeout: in HDR or DRAIN, a counter increments on every cycle with no accepted byte and resets on accept. Reaching RX_TIMEOUT → REPORT with malformed. Partial bytes are dropped.
- Busy counter (4 bits, saturating):
  - A well-formed Busy error increments it.
  - If the new count < MAX_BUSY_RETRIES → busy_retry pulse.
  - If the new count equals MAX_BUSY_RETRIES → busy_give_up=1 (held), no busy_retry.
  - Any other well-formed result (error or non-error) clears the counter.
  - A malformed result leaves the counter unchanged.
  - clear also zeroes the counter.
- Enable=0: FSM forced to IDLE next cycle, partial message discarded, rx_ready=0, no err_valid. Held outputs and busy counter are retained.
- clear coinciding with REPORT: the new result wins; clear affects only state not written by that report.
- reset mid-message: everything returns to reset values next cycle; no err_valid.

Decomposition:
- Shared defines/package: SIZE_OF_HEADER_VARS (8), SIZE_OF_HEADER_IN_BYTES (4), PROTOCOL_VERSION, ERROR_RESP_CMD, the error-code constants (0x01..0x04), and the FSM state encodings. These are shared with the ERROR response builder so both ends agree.
- One sub-module: busy_retry_tracker (saturating counter, retry/give-up logic). The FSM and header capture stay in the top module.

Test Plan:
- Bytes 01 7F 03 00 with last on byte 3 → err_valid at N+1, is_error_resp=1, Error_Busy=1, param1=0x03, busy_retry=1.
- Three consecutive Busy messages, MAX_BUSY_RETRIES=3 → busy_retry on the first two; third gives busy_give_up=1, busy_retry=0. A following 01 7F 04 00 → Error_Unspecified=1, counter cleared, busy_give_up still 1 until clear.
- 01 7F 02 01 → Error_Unsupported_Protocol=1, param2=0x01. Then 01 7F 09 00 → Error_Unknown_Code=1.
- 01 7F with last on byte 1 → malformed=1, flags 0, param1/param2=0. Bytes 01 7F 01 00 AA (last on AA) → malformed=1.
- 01 83 00 00 followed by 8 payload bytes → is_error_resp=0, malformed=0, err_valid one cycle after the final byte. Wrong version 02 7F 01 00 → malformed=1.
- Stall RX_TIMEOUT cycles after byte 2 → malformed. Deassert Enable mid-header → no err_valid, prior flags held. Assert reset mid-message → all outputs 0 next cycle.

Source files
------------

// File: rtl/error_response_decoder_pkg.sv
// Shared header layout, protocol constants and FSM encoding for the ERROR response
// decoder; the ERROR response builder imports the same package so both ends agree.
package error_response_decoder_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 8;
  localparam int SIZE_OF_HEADER_IN_BYTES = 4;
  localparam int BUSY_CNT_W              = 4;

  localparam logic [SIZE_OF_HEADER_VARS-1:0] PROTOCOL_VERSION = 8'h01;
  localparam logic [SIZE_OF_HEADER_VARS-1:0] ERROR_RESP_CMD   = 8'h7F;

  localparam logic [SIZE_OF_HEADER_VARS-1:0] ERR_INVALID_REQUEST      = 8'h01;
  localparam logic [SIZE_OF_HEADER_VARS-1:0] ERR_UNSUPPORTED_PROTOCOL = 8'h02;
  localparam logic [SIZE_OF_HEADER_VARS-1:0] ERR_BUSY                 = 8'h03;
  localparam logic [SIZE_OF_HEADER_VARS-1:0] ERR_UNSPECIFIED          = 8'h04;

  typedef logic [SIZE_OF_HEADER_VARS-1:0] hdr_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef struct packed {
    logic      is_error_resp;
    logic      invalid_request;
    logic      unsupported_protocol;
    logic      busy;
    logic      unspecified;
    logic      unknown_code;
    logic      malformed;
    hdr_byte_t param1;
    hdr_byte_t param2;
  } result_t;

  // Framing errors outrank a bad version, which outranks the MessageType check.
  function automatic result_t classify(input hdr_byte_t b0, input hdr_byte_t b1,
                                       input hdr_byte_t b2, input hdr_byte_t b3,
                                       input logic framing_err, input logic has_payload,
                                       input logic has_params);
    result_t r;
    r = '0;
    if (has_params) begin
      r.param1 = b2;
      r.param2 = b3;
    end
    if (framing_err || (has_payload && b1 == ERROR_RESP_CMD) || b0 != PROTOCOL_VERSION) begin
      r.malformed = 1'b1;
    end else if (b1 == ERROR_RESP_CMD) begin
      r.is_error_resp = 1'b1;
      case (b2)
        ERR_INVALID_REQUEST:      r.invalid_request      = 1'b1;
        ERR_UNSUPPORTED_PROTOCOL: r.unsupported_protocol = 1'b1;
        ERR_BUSY:                 r.busy                 = 1'b1;
        ERR_UNSPECIFIED:          r.unspecified          = 1'b1;
        default:                  r.unknown_code         = 1'b1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/busy_retry_tracker.sv
// Counts consecutive well-formed Busy errors and turns them into retry pulses
// or a sticky give-up once the retry budget is spent.
module busy_retry_tracker
  import error_response_decoder_pkg::*;
#(
  parameter int MAX_BUSY_RETRIES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_commit,
  input  logic i_well_formed,
  input  logic i_busy,
  input  logic i_clear,
  output logic o_busy_retry,
  output logic o_busy_give_up
);

  localparam logic [BUSY_CNT_W-1:0] MAX_CNT = BUSY_CNT_W'(MAX_BUSY_RETRIES);

  logic [BUSY_CNT_W-1:0] r_cnt;
  logic                  r_give_up;
  logic [BUSY_CNT_W-1:0] w_inc;
  logic                  w_busy_event;
  logic                  w_other_event;
  logic                  w_hit_max;

  assign w_inc         = (r_cnt == '1) ? r_cnt : r_cnt + BUSY_CNT_W'(1);
  assign w_busy_event  = i_commit & i_well_formed & i_busy;
  assign w_other_event = i_commit & i_well_formed & ~i_busy;
  assign w_hit_max     = w_busy_event & (w_inc == MAX_CNT);

  assign o_busy_retry   = w_busy_event & (w_inc < MAX_CNT);
  assign o_busy_give_up = r_give_up | w_hit_max;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the statements are written in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_give_up <= 1'b0;
    end else begin
      // A report writing the counter wins over a coincident clear.
      if (w_busy_event)                   r_cnt <= w_inc;
      else if (w_other_event || i_clear)  r_cnt <= '0;

      if (w_hit_max)    r_give_up <= 1'b1;
      else if (i_clear) r_give_up <= 1'b0;
    end
  end

endmodule

// File: rtl/error_response_decoder.sv
// Byte-serial parser for authentication responses: captures the 4-byte header,
// classifies ERROR responses and reports one result per message.
module error_response_decoder
  import error_response_decoder_pkg::*;
#(
  parameter int MAX_BUSY_RETRIES = 3,
  parameter int RX_TIMEOUT       = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Enable,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic       err_valid,
  output logic       is_error_resp,
  output logic       Error_Invalid_Request,
  output logic       Error_Unsupported_Protocol,
  output logic       Error_Busy,
  output logic       Error_Unspecified,
  output logic       Error_Unknown_Code,
  output logic [7:0] param1,
  output logic [7:0] param2,
  output logic       malformed,
  output logic       busy_retry,
  output logic       busy_give_up,
  input  logic       clear
);

  localparam logic [9:0] TO_LAST = 10'(RX_TIMEOUT - 1);

  state_t r_state;
  state_t w_state_next;

  logic [SIZE_OF_HEADER_IN_BYTES-1:0][SIZE_OF_HEADER_VARS-1:0] r_hdr;
  logic [1:0] r_idx;
  logic       r_full;
  logic       r_framing_err;
  logic       r_payload;
  logic [9:0] r_to_cnt;
  result_t    r_held;

  logic    w_accept;
  logic    w_in_msg;
  logic    w_timeout;
  logic    w_commit;
  result_t w_result;
  result_t w_out;

  assign rx_ready  = Enable & ~reset & (r_state != ST_REPORT);
  assign w_accept  = rx_valid & rx_ready;
  assign w_in_msg  = (r_state == ST_HDR) || (r_state == ST_DRAIN);
  assign w_timeout = w_in_msg & ~w_accept & (r_to_cnt == TO_LAST);
  assign w_commit  = (r_state == ST_REPORT) & Enable & ~reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (!Enable) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_next = rx_last ? ST_REPORT : ST_HDR;
        end
        ST_HDR: begin
          if (w_accept) begin
            if (rx_last)            w_state_next = ST_REPORT;
            else if (r_idx == 2'd3) w_state_next = ST_DRAIN;
          end else if (w_timeout) begin
            w_state_next = ST_REPORT;
          end
        end
        ST_DRAIN: begin
          if ((w_accept && rx_last) || w_timeout) w_state_next = ST_REPORT;
        end
        ST_REPORT: w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: the header bytes are ordinary flops and are reset with everything
  // else so a message cut short never reports stale header contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr         <= '0;
      r_idx         <= '0;
      r_full        <= 1'b0;
      r_framing_err <= 1'b0;
      r_payload     <= 1'b0;
      r_to_cnt      <= '0;
    end else if (!Enable) begin
      r_idx    <= '0;
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_hdr         <= {24'h0, rx_byte};
        r_idx         <= 2'd1;
        r_full        <= 1'b0;
        r_framing_err <= rx_last;
        r_payload     <= 1'b0;
        r_to_cnt      <= '0;
      end
    end else if (w_in_msg) begin
      if (w_accept) begin
        r_to_cnt <= '0;
        if (r_state == ST_HDR) begin
          r_hdr[r_idx] <= rx_byte;
          r_idx        <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_full    <= 1'b1;
            r_payload <= ~rx_last;
          end else if (rx_last) begin
            r_framing_err <= 1'b1;
          end
        end
      end else begin
        r_to_cnt <= r_to_cnt + 10'd1;
        if (w_timeout) r_framing_err <= 1'b1;
      end
    end else begin
      r_idx    <= '0;
      r_to_cnt <= '0;
    end
  end

  assign w_result = classify(r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3],
                             r_framing_err, r_payload, r_full);

  // The fresh result is visible during REPORT and becomes the held value after it.
  always_ff @(posedge clk) begin
    if (reset)         r_held <= '0;
    else if (w_commit) r_held <= w_result;
    else if (clear)    r_held <= '0;
  end

  assign w_out = w_commit ? w_result : r_held;

  assign err_valid                  = w_commit;
  assign is_error_resp              = w_out.is_error_resp;
  assign Error_Invalid_Request      = w_out.invalid_request;
  assign Error_Unsupported_Protocol = w_out.unsupported_protocol;
  assign Error_Busy                 = w_out.busy;
  assign Error_Unspecified          = w_out.unspecified;
  assign Error_Unknown_Code         = w_out.unknown_code;
  assign malformed                  = w_out.malformed;
  assign param1                     = w_out.param1;
  assign param2                     = w_out.param2;

  busy_retry_tracker #(
    .MAX_BUSY_RETRIES(MAX_BUSY_RETRIES)
  ) u_busy_retry_tracker (
    .clk           (clk),
    .reset         (reset),
    .i_commit      (w_commit),
    .i_well_formed (~w_result.malformed),
    .i_busy        (w_result.busy),
    .i_clear       (clear),
    .o_busy_retry  (busy_retry),
    .o_busy_give_up(busy_give_up)
  );

endmodule

// File: tb/tb_error_response_decoder.sv
// Directed bench for error_response_decoder: hand-computed expectations for each
// message type, busy retry/give-up, framing errors, timeout, Enable and reset.
module tb_error_response_decoder;

  logic       clk;
  logic       reset;
  logic       Enable;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready;
  logic       err_valid;
  logic       is_error_resp;
  logic       Error_Invalid_Request;
  logic       Error_Unsupported_Protocol;
  logic       Error_Busy;
  logic       Error_Unspecified;
  logic       Error_Unknown_Code;
  logic [7:0] param1;
  logic [7:0] param2;
  logic       malformed;
  logic       busy_retry;
  logic       busy_give_up;
  logic       clear;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  q[$];
  logic [25:0] w_obs;

  error_response_decoder #(
    .MAX_BUSY_RETRIES(3),
    .RX_TIMEOUT      (1023)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .Enable                    (Enable),
    .rx_byte                   (rx_byte),
    .rx_valid                  (rx_valid),
    .rx_last                   (rx_last),
    .rx_ready                  (rx_ready),
    .err_valid                 (err_valid),
    .is_error_resp             (is_error_resp),
    .Error_Invalid_Request     (Error_Invalid_Request),
    .Error_Unsupported_Protocol(Error_Unsupported_Protocol),
    .Error_Busy                (Error_Busy),
    .Error_Unspecified         (Error_Unspecified),
    .Error_Unknown_Code        (Error_Unknown_Code),
    .param1                    (param1),
    .param2                    (param2),
    .malformed                 (malformed),
    .busy_retry                (busy_retry),
    .busy_give_up              (busy_give_up),
    .clear                     (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {err_valid, is_error_resp, inv, unsup, busy, unspec, unknown,
  //               malformed, busy_retry, busy_give_up, param1, param2}
  assign w_obs = {err_valid, is_error_resp, Error_Invalid_Request, Error_Unsupported_Protocol,
                  Error_Busy, Error_Unspecified, Error_Unknown_Code, malformed,
                  busy_retry, busy_give_up, param1, param2};

  function automatic logic [25:0] expv(input logic v, input logic ie, input logic inv,
                                       input logic uns, input logic bsy, input logic unsp,
                                       input logic unk, input logic mal, input logic rt,
                                       input logic gu, input logic [7:0] p1,
                                       input logic [7:0] p2);
    return {v, ie, inv, uns, bsy, unsp, unk, mal, rt, gu, p1, p2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives q back to back; returns #1 after the edge that accepted the final byte.
  task automatic send_msg(input bit end_last);
    for (int i = 0; i < q.size(); i++) begin
      rx_valid = 1'b1;
      rx_byte  = q[i];
      rx_last  = end_last && (i == q.size() - 1);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_busy(input string tag, input logic rt, input logic gu);
    q = '{8'h01, 8'h7F, 8'h03, 8'h00};
    send_msg(1'b1);
    check(tag, w_obs, expv(1, 1, 0, 0, 1, 0, 0, 0, rt, gu, 8'h03, 8'h00));
    step();
  endtask

  initial begin
    int wait_cycles;
    reset    = 1'b1;
    Enable   = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", w_obs, 26'h0);
    check("reset_rx_ready", rx_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_rx_ready", rx_ready, 1);

    // First Busy: result at N+1 with a retry pulse, then held without pulses.
    q = '{8'h01, 8'h7F, 8'h03, 8'h00};
    send_msg(1'b1);
    check("busy1_report", w_obs, expv(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8'h03, 8'h00));
    check("report_rx_ready", rx_ready, 0);
    step();
    check("busy1_held", w_obs, expv(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h03, 8'h00));
    check("busy1_rx_ready_back", rx_ready, 1);

    send_busy("busy2_retry", 1, 0);
    send_busy("busy3_give_up", 0, 1);

    q = '{8'h01, 8'h7F, 8'h04, 8'h00};
    send_msg(1'b1);
    check("unspecified_report", w_obs, expv(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 8'h04, 8'h00));
    step();
    check("give_up_still_held", busy_give_up, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_all", w_obs, 26'h0);

    // Counter was cleared by the Unspecified error, so the next Busy retries.
    send_busy("busy_after_clear", 1, 0);

    q = '{8'h01, 8'h7F, 8'h02, 8'h01};
    send_msg(1'b1);
    check("unsupported_proto", w_obs, expv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h02, 8'h01));
    step();

    q = '{8'h01, 8'h7F, 8'h09, 8'h00};
    send_msg(1'b1);
    check("unknown_code", w_obs, expv(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h09, 8'h00));
    step();

    // Two Busys, then malformed messages must not disturb the count of 2.
    send_busy("busy_a", 1, 0);
    send_busy("busy_b", 1, 0);

    q = '{8'h01, 8'h7F};
    send_msg(1'b1);
    check("short_msg", w_obs, expv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step();

    q = '{8'h01, 8'h7F, 8'h01, 8'h00, 8'hAA};
    send_msg(1'b1);
    check("error_with_payload", w_obs, expv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'h00));
    step();

    send_busy("busy_c_give_up", 0, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;

    q = '{8'h01, 8'h83, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
          8'h14, 8'h15, 8'h16, 8'h17};
    send_msg(1'b1);
    check("non_error_payload", w_obs, expv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    step();

    q = '{8'h02, 8'h7F, 8'h01, 8'h00};
    send_msg(1'b1);
    check("wrong_version", w_obs, expv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h01, 8'h00));
    step();

    // Stall after byte 2: REPORT is reached after exactly RX_TIMEOUT idle cycles.
    q = '{8'h01, 8'h7F, 8'h03};
    send_msg(1'b0);
    wait_cycles = 0;
    while (!err_valid && wait_cycles < 1100) begin
      step();
      wait_cycles++;
    end
    check("timeout_cycles", wait_cycles, 1023);
    check("timeout_report", w_obs, expv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    step();

    // Enable dropped mid-header: partial message discarded, held flags kept.
    q = '{8'h01, 8'h7F};
    send_msg(1'b0);
    Enable = 1'b0;
    #1;
    check("disable_rx_ready", rx_ready, 0);
    check("disable_held", w_obs, expv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    repeat (3) step();
    check("disable_no_report", w_obs, expv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
    Enable = 1'b1;
    #1;
    q = '{8'h01, 8'h7F, 8'h01, 8'h00};
    send_msg(1'b1);
    check("invalid_after_enable", w_obs, expv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00));
    step();

    // Reset mid-message returns every output to zero on the next cycle.
    q = '{8'h01, 8'h7F, 8'h02};
    send_msg(1'b0);
    reset = 1'b1;
    step();
    check("reset_mid_msg", w_obs, 26'h0);
    check("reset_mid_rx_ready", rx_ready, 0);
    reset = 1'b0;
    #1;
    send_busy("busy_after_reset", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
